// File: rtl/video_timing_pkg.sv
// Shared raster timing constants and coordinate widths for the overlay path.
// Defaults describe 800x600@60 on a 40 MHz pixel clock.
package video_timing_pkg;

  localparam int GR_X_W = 11;
  localparam int GR_Y_W = 10;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;

  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 23;

  function automatic logic in_win(
    input int v,
    input int lo,
    input int len
  );
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/raster_axis_counter.sv
// Free-running modulo-TOTAL counter for one raster axis.
// wrap flags the last count so the next axis can chain off it.
module raster_axis_counter #(
  parameter int TOTAL = 8,
  parameter int W     = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = (cnt == W'(TOTAL - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/raster_timing_gen.sv
// Pixel raster generator: h/v counters, syncs, display enable, coordinates.
// Outputs are registered decodes of the pre-increment counter values.
module raster_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [GR_X_W-1:0] gr_x,
  output logic [GR_Y_W-1:0] gr_y,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              line_start,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [GR_X_W-1:0] w_h_cnt;
  logic [GR_Y_W-1:0] w_v_cnt;
  logic              w_h_wrap;
  logic              w_v_wrap;
  logic              w_hs_act;
  logic              w_vs_act;
  logic              w_de;
  logic              w_h_zero;
  logic              w_v_zero;

  raster_axis_counter #(
    .TOTAL (H_TOTAL),
    .W     (GR_X_W)
  ) u_h_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (enable),
    .cnt   (w_h_cnt),
    .wrap  (w_h_wrap)
  );

  raster_axis_counter #(
    .TOTAL (V_TOTAL),
    .W     (GR_Y_W)
  ) u_v_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (enable & w_h_wrap),
    .cnt   (w_v_cnt),
    .wrap  (w_v_wrap)
  );

  assign w_hs_act = in_win(int'(w_h_cnt), H_ACTIVE + H_FP, H_SYNC);
  assign w_vs_act = in_win(int'(w_v_cnt), V_ACTIVE + V_FP, V_SYNC);
  assign w_de     = in_win(int'(w_h_cnt), 0, H_ACTIVE)
                  & in_win(int'(w_v_cnt), 0, V_ACTIVE);
  assign w_h_zero = (w_h_cnt == '0);
  assign w_v_zero = (w_v_cnt == '0);

  // Pulses only fire on advancing edges; everything else holds when frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gr_x        <= '0;
      gr_y        <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (enable) begin
      gr_x        <= w_h_cnt;
      gr_y        <= w_v_cnt;
      hsync       <= w_hs_act ? HS_POL : ~HS_POL;
      vsync       <= w_vs_act ? VS_POL : ~VS_POL;
      de          <= w_de;
      line_start  <= w_h_zero;
      frame_start <= w_h_zero & w_v_zero;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule
